ao_result_collector: RTL and testbench

Downstream consumer of the ambient-occlusion ray-tracing core (TOP_AO). It accepts one per-ray hit result (ray id, hitT) per cycle and classifies each ray as occluded or a miss. It accumulates the per-pixel occlusion count over SAMPLES_PER_PIXEL rays and emits one completed-pixel record per pixel on a valid/ready stream. It also tracks run statistics and raises a sticky done once the core reports finish and all in-flight work has drained.

---
 rtl/ao_result_collector.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ao_result_collector.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ao_result_collector.sv
// Ambient-occlusion result collector.
// Accepts one per-ray hit result per cycle, accumulates per-pixel occlusion
// counts in a synchronous-read pixel table, emits one record per completed
// pixel on a valid/ready stream, keeps run statistics and raises a sticky
// done once the core has finished and all in-flight work has drained.
module ao_result_collector #(
  parameter int          SAMPLES_PER_PIXEL = 8,
  parameter int          NUM_PIXELS        = 1024,
  parameter logic [31:0] MISS_HITT         = 32'h7F7FFFFF,
  localparam int         PIX_W             = $clog2(NUM_PIXELS),
  localparam int         SPP_W             = $clog2(SAMPLES_PER_PIXEL),
  localparam int         CNT_W             = SPP_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_ray_id,
  input  logic [31:0]      io_in_hitT,
  input  logic             io_rtp_finish,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [PIX_W-1:0] io_out_pixel_id,
  output logic [CNT_W-1:0] io_out_occ_count,
  output logic             io_done,
  output logic [31:0]      io_ray_count,
  output logic [31:0]      io_hit_count,
  output logic [15:0]      io_drop_count,
  output logic [PIX_W:0]   io_pending_pixels
);

  localparam int               ENTRY_W      = 2 * CNT_W;
  localparam logic [CNT_W-1:0] SPP_C        = CNT_W'(SAMPLES_PER_PIXEL);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
  localparam logic [PIX_W:0]   PEND_ONE_C   = {{PIX_W{1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] ADDR_ONE_C   = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] LAST_ADDR_C  = PIX_W'(NUM_PIXELS - 1);
  localparam logic [31:0]      NUM_PIXELS_C = 32'(NUM_PIXELS);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [PIX_W-1:0]   init_addr_r;

  logic               stall_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               in_range_s;
  logic [PIX_W-1:0]   in_pix_s;
  logic               in_occ_s;

  // Pipeline register: the accepted result whose table read is in flight.
  logic               s1_valid_r;
  logic [PIX_W-1:0]   s1_pix_r;
  logic               s1_occ_r;

  // Pixel table and its read data register.
  logic [ENTRY_W-1:0] mem_r [NUM_PIXELS];
  logic [ENTRY_W-1:0] rd_data_r;

  // The write that happened in the same cycle as the held read; the RAM
  // returns old data on a read/write collision, so this copy is forwarded.
  logic               fwd_valid_r;
  logic [PIX_W-1:0]   fwd_pix_r;
  logic [ENTRY_W-1:0] fwd_data_r;

  logic [ENTRY_W-1:0] cur_data_s;
  logic [CNT_W-1:0]   cur_samples_s;
  logic [CNT_W-1:0]   cur_occ_s;
  logic [CNT_W-1:0]   new_samples_s;
  logic [CNT_W-1:0]   new_occ_s;
  logic               s2_fire_s;
  logic               complete_s;

  logic               wr_en_s;
  logic [PIX_W-1:0]   wr_addr_s;
  logic [ENTRY_W-1:0] wr_data_s;

  logic               out_valid_r;
  logic [PIX_W-1:0]   out_pixel_r;
  logic [CNT_W-1:0]   out_occ_r;
  logic [31:0]        ray_count_r;
  logic [31:0]        hit_count_r;
  logic [15:0]        drop_count_r;
  logic [PIX_W:0]     pending_r;

  // Input handshake, range check and classification of the offered result.
  always_comb begin
    stall_s = out_valid_r && !io_out_ready;
    if (state_r == ST_RUN) begin
      in_ready_s = !stall_s;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s   = io_in_valid && in_ready_s;
    in_range_s = (io_in_ray_id >> SPP_W) < NUM_PIXELS_C;
    in_pix_s   = io_in_ray_id[SPP_W +: PIX_W];
    in_occ_s   = (io_in_hitT != MISS_HITT);
  end

  // Second stage: pick current entry (forwarded or read) and update it.
  always_comb begin
    if (fwd_valid_r && (fwd_pix_r == s1_pix_r)) begin
      cur_data_s = fwd_data_r;
    end else begin
      cur_data_s = rd_data_r;
    end
    cur_samples_s = cur_data_s[ENTRY_W-1:CNT_W];
    cur_occ_s     = cur_data_s[CNT_W-1:0];
    new_samples_s = cur_samples_s + CNT_ONE_C;
    new_occ_s     = cur_occ_s + {{(CNT_W-1){1'b0}}, s1_occ_r};
    s2_fire_s     = s1_valid_r && !stall_s;
    complete_s    = (new_samples_s == SPP_C);
  end

  // Table write port: clearing sweep during INIT, otherwise the stage-2 update.
  always_comb begin
    if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_addr_s = init_addr_r;
      wr_data_s = {ENTRY_W{1'b0}};
    end else if (s2_fire_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = s1_pix_r;
      if (complete_s) begin
        wr_data_s = {ENTRY_W{1'b0}};
      end else begin
        wr_data_s = {new_samples_s, new_occ_s};
      end
    end else begin
      wr_en_s   = 1'b0;
      wr_addr_s = {PIX_W{1'b0}};
      wr_data_s = {ENTRY_W{1'b0}};
    end
  end

  // Pixel table storage; cleared by the INIT sweep rather than by reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Synchronous table read plus capture of the colliding write; both hold on stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r   <= {ENTRY_W{1'b0}};
      fwd_valid_r <= 1'b0;
      fwd_pix_r   <= {PIX_W{1'b0}};
      fwd_data_r  <= {ENTRY_W{1'b0}};
    end else if (!stall_s) begin
      rd_data_r   <= mem_r[in_pix_s];
      fwd_valid_r <= wr_en_s;
      fwd_pix_r   <= wr_addr_s;
      fwd_data_r  <= wr_data_s;
    end
  end

  // First-stage register: only in-range accepted results enter the pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_pix_r   <= {PIX_W{1'b0}};
      s1_occ_r   <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s && in_range_s;
      s1_pix_r   <= in_pix_s;
      s1_occ_r   <= in_occ_s;
    end
  end

  // Output record register: load on completion, clear after acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_pixel_r <= {PIX_W{1'b0}};
      out_occ_r   <= {CNT_W{1'b0}};
    end else if (s2_fire_s && complete_s) begin
      out_valid_r <= 1'b1;
      out_pixel_r <= s1_pix_r;
      out_occ_r   <= new_occ_s;
    end else if (out_valid_r && io_out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Ray and hit statistics, counted as each in-range result is folded in.
  always_ff @(posedge clock) begin
    if (reset) begin
      ray_count_r <= 32'd0;
      hit_count_r <= 32'd0;
    end else if (s2_fire_s) begin
      ray_count_r <= ray_count_r + 32'd1;
      hit_count_r <= hit_count_r + {31'd0, s1_occ_r};
    end
  end

  // Saturating count of out-of-range rays rejected at acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_r <= 16'd0;
    end else if (accept_s && !in_range_s && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end
  end

  // Number of partially accumulated pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= {(PIX_W+1){1'b0}};
    end else if (s2_fire_s && complete_s) begin
      pending_r <= pending_r - PEND_ONE_C;
    end else if (s2_fire_s && (cur_samples_s == CNT_ZERO_C)) begin
      pending_r <= pending_r + PEND_ONE_C;
    end
  end

  // Clearing-sweep address, advanced once per INIT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_addr_r <= {PIX_W{1'b0}};
    end else if (state_r == ST_INIT) begin
      init_addr_r <= init_addr_r + ADDR_ONE_C;
    end else begin
      init_addr_r <= {PIX_W{1'b0}};
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Control next-state: sweep, run, drain in-flight work, then hold done.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_addr_r == LAST_ADDR_C) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (io_rtp_finish && !accept_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_r && !out_valid_r) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_DONE;
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  assign io_in_ready       = in_ready_s;
  assign io_out_valid      = out_valid_r;
  assign io_out_pixel_id   = out_pixel_r;
  assign io_out_occ_count  = out_occ_r;
  assign io_done           = (state_r == ST_DONE);
  assign io_ray_count      = ray_count_r;
  assign io_hit_count      = hit_count_r;
  assign io_drop_count     = drop_count_r;
  assign io_pending_pixels = pending_r;

endmodule

// File: tb/tb_ao_result_collector.sv
// Bench for ao_result_collector: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a per-pixel reference model.
module tb_ao_result_collector;

  localparam int          SPP   = 8;
  localparam int          NPIX  = 1024;
  localparam int          SPP_W = 3;
  localparam int          PIX_W = 10;
  localparam int          CNT_W = 4;
  localparam logic [31:0] MISS  = 32'h7F7FFFFF;
  localparam logic [31:0] HIT   = 32'h3F800000;

  logic             clock;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [31:0]      io_in_ray_id;
  logic [31:0]      io_in_hitT;
  logic             io_rtp_finish;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [PIX_W-1:0] io_out_pixel_id;
  logic [CNT_W-1:0] io_out_occ_count;
  logic             io_done;
  logic [31:0]      io_ray_count;
  logic [31:0]      io_hit_count;
  logic [15:0]      io_drop_count;
  logic [PIX_W:0]   io_pending_pixels;

  int vectors;
  int miscompares;

  // Reference model state
  int          m_samp [NPIX];
  int          m_occ  [NPIX];
  int          m_pending;
  logic [31:0] m_rays;
  logic [31:0] m_hits;
  int          m_drops;
  int          exp_pix_q [$];
  int          exp_occ_q [$];

  logic ready_fixed;
  logic rand_ready;

  longint unsigned mi_rid;
  int              mi_pix;
  int              mo_pix;
  int              mo_occ;
  logic            held_v;
  logic [PIX_W-1:0] held_pix;
  logic [CNT_W-1:0] held_occ;

  ao_result_collector #(
    .SAMPLES_PER_PIXEL(SPP),
    .NUM_PIXELS(NPIX),
    .MISS_HITT(MISS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_ray_id(io_in_ray_id),
    .io_in_hitT(io_in_hitT),
    .io_rtp_finish(io_rtp_finish),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_pixel_id(io_out_pixel_id),
    .io_out_occ_count(io_out_occ_count),
    .io_done(io_done),
    .io_ray_count(io_ray_count),
    .io_hit_count(io_hit_count),
    .io_drop_count(io_drop_count),
    .io_pending_pixels(io_pending_pixels)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink-ready driver: fixed level or random 75% ready.
  initial begin
    io_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      io_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  // Input monitor: every accepted result updates the reference model.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        foreach (m_samp[i]) begin
          m_samp[i] = 0;
          m_occ[i]  = 0;
        end
        m_pending = 0;
        m_rays    = 32'd0;
        m_hits    = 32'd0;
        m_drops   = 0;
        exp_pix_q.delete();
        exp_occ_q.delete();
      end else if (io_in_valid && io_in_ready) begin
        mi_rid = io_in_ray_id;
        if (mi_rid / SPP >= NPIX) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          mi_pix = int'(mi_rid / SPP);
          if (m_samp[mi_pix] == 0) m_pending++;
          m_samp[mi_pix]++;
          m_rays = m_rays + 32'd1;
          if (io_in_hitT != MISS) begin
            m_occ[mi_pix]++;
            m_hits = m_hits + 32'd1;
          end
          if (m_samp[mi_pix] == SPP) begin
            exp_pix_q.push_back(mi_pix);
            exp_occ_q.push_back(m_occ[mi_pix]);
            m_samp[mi_pix] = 0;
            m_occ[mi_pix]  = 0;
            m_pending--;
          end
        end
      end
    end
  end

  // Output monitor: pops expected records on transfer, checks hold stability.
  initial begin
    held_v = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_valid", io_out_valid, 1);
          chk("hold_pixel", io_out_pixel_id, held_pix);
          chk("hold_occ", io_out_occ_count, held_occ);
        end
        if (io_out_valid && io_out_ready) begin
          if (exp_pix_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_record: pixel %0d occ %0d with no record expected", io_out_pixel_id, io_out_occ_count);
          end else begin
            mo_pix = exp_pix_q.pop_front();
            mo_occ = exp_occ_q.pop_front();
            chk("rec_pixel", io_out_pixel_id, mo_pix);
            chk("rec_occ", io_out_occ_count, mo_occ);
          end
        end
        held_v   = io_out_valid && !io_out_ready;
        held_pix = io_out_pixel_id;
        held_occ = io_out_occ_count;
      end
    end
  end

  // Global time bound.
  initial begin
    #3_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [31:0] rid, input logic [31:0] ht);
    int n;
    n = 0;
    io_in_valid  = 1'b1;
    io_in_ray_id = rid;
    io_in_hitT   = ht;
    @(negedge clock);
    while (!io_in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!io_in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: ray %0d not accepted, in_ready %0b", rid, io_in_ready);
    end
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_ray_count"}, io_ray_count, m_rays);
    chk({tag, "_hit_count"}, io_hit_count, m_hits);
    chk({tag, "_drop_count"}, io_drop_count, m_drops);
    chk({tag, "_pending"}, io_pending_pixels, m_pending);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset         = 1'b1;
    io_in_valid   = 1'b0;
    io_rtp_finish = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", io_in_ready, 0);
    chk("rst_out_valid", io_out_valid, 0);
    chk("rst_pixel", io_out_pixel_id, 0);
    chk("rst_occ", io_out_occ_count, 0);
    chk("rst_done", io_done, 0);
    chk("rst_counters", {io_ray_count, io_hit_count} | 64'(io_drop_count) | 64'(io_pending_pixels), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clock);
      chk("init_in_ready", io_in_ready, 0);
      chk("init_outputs_zero", io_out_valid | io_done | (|io_out_pixel_id) | (|io_out_occ_count) |
          (|io_ray_count) | (|io_hit_count) | (|io_drop_count) | (|io_pending_pixels), 0);
    end
    @(negedge clock);
    chk("init_ready_rise", io_in_ready, 1);
    @(posedge clock);
    #1;
  endtask

  logic [31:0] rid;
  logic [31:0] ht;

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    io_in_valid   = 1'b0;
    io_in_ray_id  = 32'd0;
    io_in_hitT    = 32'd0;
    io_rtp_finish = 1'b0;
    ready_fixed   = 1'b1;
    rand_ready    = 1'b0;

    do_reset();

    // Pixel 3: five hits, three misses, back to back; check latency.
    for (int k = 0; k < 8; k++) send(32'd24 + 32'(k), (k < 5) ? HIT : MISS);
    @(negedge clock);
    chk("p3_pending_mid", io_pending_pixels, 1);
    chk("p3_valid_t1", io_out_valid, 0);
    @(negedge clock);
    chk("p3_valid_t2", io_out_valid, 1);
    chk("p3_pixel", io_out_pixel_id, 3);
    chk("p3_occ", io_out_occ_count, 5);
    chk("p3_pending_end", io_pending_pixels, 0);
    idle(3);
    chk("p3_ray_count", io_ray_count, 8);
    chk("p3_hit_count", io_hit_count, 5);
    check_counters("p3");

    // Pixels 0 and 1 interleaved, all hits.
    for (int k = 0; k < 4; k++) begin
      send(32'(k), HIT);
      send(32'd8 + 32'(k), HIT);
    end
    idle(3);
    chk("il_no_output", io_out_valid, 0);
    chk("il_pending", io_pending_pixels, 2);
    for (int k = 4; k < 8; k++) begin
      send(32'(k), HIT);
      send(32'd8 + 32'(k), HIT);
    end
    idle(4);
    check_counters("il");

    // Pixel 5 completes while the sink is stalled for 10 cycles.
    ready_fixed = 1'b0;
    idle(1);
    for (int k = 0; k < 8; k++) send(32'd40 + 32'(k), (k % 2 == 0) ? HIT : MISS);
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #1;
    io_in_valid  = 1'b1;
    io_in_ray_id = 32'd48;
    io_in_hitT   = HIT;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("stall_valid", io_out_valid, 1);
      chk("stall_in_ready", io_in_ready, 0);
      chk("stall_pixel", io_out_pixel_id, 5);
    end
    @(posedge clock);
    #1;
    ready_fixed = 1'b1;
    for (int k = 0; k < 8; k++) send(32'd48 + 32'(k), (k < 6) ? HIT : MISS);
    idle(4);
    check_counters("stall");

    // Out-of-range ray.
    send(32'd8192, HIT);
    idle(3);
    chk("drop_count", io_drop_count, 1);
    chk("drop_no_record", io_out_valid, 0);
    check_counters("drop");

    // Randomized traffic on a few pixels with random sink back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) rid = $urandom | 32'h0000_2000;
      else rid = 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      ht = ($urandom_range(0, 1) == 0) ? MISS : $urandom;
      send(rid, ht);
    end
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    idle(6);
    check_counters("rand");
    chk("rand_queue_drained", exp_pix_q.size(), 0);

    // Reset mid-run with a partial pixel and a held record.
    ready_fixed = 1'b0;
    idle(1);
    for (int k = 0; k < 3; k++) send(32'd240 + 32'(k), HIT);
    for (int k = 0; k < 8; k++) send(32'd72 + 32'(k), HIT);
    idle(3);
    chk("midrst_held", io_out_valid, 1);
    ready_fixed = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) send(32'd240 + 32'(k), MISS);
    idle(4);
    chk("midrst_pending", io_pending_pixels, 0);
    check_counters("midrst");

    // Finish with one partial pixel and a record pending.
    ready_fixed = 1'b0;
    idle(1);
    for (int k = 0; k < 3; k++) send(32'd168 + 32'(k), HIT);
    for (int k = 0; k < 7; k++) send(32'd160 + 32'(k), MISS);
    io_rtp_finish = 1'b1;
    send(32'd167, HIT);
    idle(4);
    chk("drain_done_low", io_done, 0);
    chk("drain_in_ready", io_in_ready, 0);
    chk("drain_valid", io_out_valid, 1);
    ready_fixed = 1'b1;
    idle(5);
    chk("done_high", io_done, 1);
    chk("done_pending", io_pending_pixels, 1);
    check_counters("done");
    io_rtp_finish = 1'b0;
    io_in_valid   = 1'b1;
    io_in_ray_id  = 32'd200;
    io_in_hitT    = HIT;
    idle(20);
    chk("done_sticky", io_done, 1);
    chk("done_in_ready", io_in_ready, 0);
    io_in_valid = 1'b0;
    check_counters("done_ignore");
    chk("done_queue_empty", exp_pix_q.size(), 0);

    do_reset();
    chk("final_done_cleared", io_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
